wb_unit: RTL
============

// Module: wb_unit
// PURPOSE
// Writeback stage of the in-order core: the producer side of the wb_to_reg request consumed by the
//   register file. Merges ALU results (buffered, valid/ready) and load responses (always accepted)
//   into at most one register write per cycle. Issues a one-cycle fetch redirect on taken branches.
// Keeps a pending-load scoreboard that the decoder uses for RAW stalls.
// PARAMETERS
// DATA_W      32  register/data width
// NREGS       32  architectural registers
// REG_W        5  register index width, $clog2(NREGS)
// FIFO_DEPTH   2  ALU result buffer entries (power of 2, >=2)
// PORTS
// clk              in   1       clock, rising edge
// arstn            in   1       reset, asynchronous, active-low
// alu_valid_i      in   1       ALU result valid
// alu_ready_o      out  1       buffer not full; transfer when valid&ready
// alu_wb_wr_i      in   1       result writes a register
// alu_reg_dst_i    in   REG_W   destination register
// alu_data_i       in   DATA_W  result data
// alu_branch_i     in   1       taken branch/jump
// alu_target_i     in   DATA_W  branch target PC
// ld_issue_i       in   1       load issued to memory this cycle
// ld_issue_dst_i   in   REG_W   load destination
// ld_rsp_valid_i   in   1       load response, no backpressure
// ld_rsp_dst_i     in   REG_W   load response destination
// ld_rsp_data_i    in   DATA_W  load data
// wb_valid_o       out  1       reg write enable (wb_to_reg valid_in)
// wb_addr_o        out  REG_W   reg write address
// wb_data_o        out  DATA_W  reg write data
// wb_pc_branch_o   out  1       further signal pc_branch to reg unit
// redirect_valid_o out  1       fetch redirect pulse
// redirect_pc_o    out  DATA_W  redirect target
// busy_o           out  NREGS   scoreboard: bit r = load to r outstanding
// err_o            out  1       sticky: load issued to an already-busy reg
// BEHAVIOUR
// - Reset: all outputs 0; FIFO empty (alu_ready_o=1 one cycle after arstn deasserts); busy_o=0; err_o=0.
// - All write/redirect outputs are registered; a write selected in cycle N appears in cycle N+1.
// - alu_ready_o = !full, derived only from the registered count; accept when valid&ready.
// - Per-cycle selection (one write max):
//   ld_rsp_valid_i -> write ld data; FIFO head is not popped.
//   else FIFO non-empty -> pop head; write when wb_wr=1; redirect when branch=1.
// - A load response always wins; ALU entries wait without bound and no entry is lost.
// - Writes with dst==0 are suppressed (wb_valid_o=0); the pop or ld clear still happens.
// - Branch pop: redirect_valid_o=1 for exactly 1 cycle with redirect_pc_o=target.
//   wb_pc_branch_o=1 in that same cycle. Remaining FIFO entries are flushed, and any ALU input
//   accepted in the pop cycle is dropped. A branch entry with wb_wr=1 (link) still writes.
// - FIFO: push and pop in the same cycle keep the count. Pointers wrap modulo FIFO_DEPTH.
//   Flush sets count=0 and overrides a simultaneous push.
// - Scoreboard: ld_issue_i sets busy[dst] and ld_rsp_valid_i clears busy[dst] (dst!=0 only).
//   Set and clear of the same reg in the same cycle: set wins. Issue to a reg with busy=1 sets err_o.
// - Idle outputs: wb_valid_o=0, redirect_valid_o=0, wb_pc_branch_o=0. Data/addr hold last value.
// - arstn asserted mid-operation: FIFO contents and pending loads are discarded immediately.
// STRUCTURE
// - Typedefs go in reg_pkg: wb_to_reg_req_t (valid_in, addr_in, data_in, fur_sig), wb_fur_sig_t,
//   alu_to_wb_t, and reg_t.
// - Sub-module wb_fifo: parameterised valid/ready FIFO with flush and count. The scoreboard and the
//   select logic stay in wb_unit.
// TESTING
// 1 Reset -> all outputs 0, alu_ready_o=1, busy_o=0.
// 2 ALU push {wr=1,dst=3,data=0xA5} -> wb_valid_o=1, addr=3, data=0xA5 two cycles after transfer.
// 3 FIFO full, then ld_rsp {dst=7,data=0x11} for 3 cycles -> 3 load writes first, then ALU entries
//   in order; alu_ready_o=0 while full.
// 4 Push branch {target=0x400} then a non-branch wr dst=5 -> one redirect pulse to 0x400, and no
//   write to r5.
// 5 ld_issue dst=9, ld_rsp dst=9 after 4 cycles -> busy_o[9] high for exactly those 4 cycles.
//   Issue and rsp to r9 in the same cycle -> stays 1.
// 6 ALU write dst=0 -> no wb_valid_o. Second issue to busy r4 -> err_o=1 sticky.
//   arstn mid-burst -> FIFO empty, no writes after release.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared types for the writeback stage and the register-file write request.
// Widths are fixed here so that every unit sees the same bus layout.
package reg_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_W      = $clog2(NREGS);
    localparam int unsigned FIFO_DEPTH = 2;

    typedef logic [REG_W-1:0] reg_t;

    typedef struct packed {
        logic pc_branch;
    } wb_fur_sig_t;

    typedef struct packed {
        logic              valid_in;
        reg_t              addr_in;
        logic [DATA_W-1:0] data_in;
        wb_fur_sig_t       fur_sig;
    } wb_to_reg_req_t;

    typedef struct packed {
        logic              wb_wr;
        reg_t              reg_dst;
        logic [DATA_W-1:0] data;
        logic              branch;
        logic [DATA_W-1:0] target;
    } alu_to_wb_t;

    localparam int unsigned ALU_TO_WB_W = $bits(alu_to_wb_t);

    // r0 is hardwired, so nothing is ever written to it or tracked for it.
    function automatic logic is_writable(reg_t r);
        return r != '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Valid/ready FIFO with synchronous flush and an occupancy count.
// Ready is a flop computed from the next count, so it is 0 during reset.
module wb_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         arstn,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ready_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push_valid && ready_q && !flush;

    // Flush wins over a simultaneous push; push+pop keeps the count.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != CNT_W'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head       = mem[rd_ptr];
    assign push_ready = ready_q;
    assign count      = cnt_q;

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: merges load responses and buffered ALU results into one
// register write per cycle, issues fetch redirects and tracks pending loads.
module wb_unit
    import reg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = reg_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic              alu_wb_wr_i,
    input  logic [REG_W-1:0]  alu_reg_dst_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_branch_i,
    input  logic [DATA_W-1:0] alu_target_i,
    input  logic              ld_issue_i,
    input  logic [REG_W-1:0]  ld_issue_dst_i,
    input  logic              ld_rsp_valid_i,
    input  logic [REG_W-1:0]  ld_rsp_dst_i,
    input  logic [DATA_W-1:0] ld_rsp_data_i,
    output logic              wb_valid_o,
    output logic [REG_W-1:0]  wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_pc_branch_o,
    output logic              redirect_valid_o,
    output logic [DATA_W-1:0] redirect_pc_o,
    output logic [NREGS-1:0]  busy_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    alu_to_wb_t        alu_in;
    alu_to_wb_t        head;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop_c;
    logic              flush_c;

    wb_to_reg_req_t    wb_q;
    wb_to_reg_req_t    wb_d;
    logic              redir_q;
    logic              redir_d;
    logic [DATA_W-1:0] redir_pc_q;
    logic [DATA_W-1:0] redir_pc_d;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic              err_q;
    logic              err_d;

    assign alu_in = '{
        wb_wr:   alu_wb_wr_i,
        reg_dst: alu_reg_dst_i,
        data:    alu_data_i,
        branch:  alu_branch_i,
        target:  alu_target_i
    };

    wb_fifo #(
        .W     (ALU_TO_WB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .arstn      (arstn),
        .push_valid (alu_valid_i),
        .push_ready (alu_ready_o),
        .push_data  (alu_in),
        .pop        (pop_c),
        .head       (head),
        .flush      (flush_c),
        .count      (fifo_count)
    );

    // Write-port arbitration: a load response always takes the slot; the ALU head waits.
    always_comb begin
        pop_c                = 1'b0;
        flush_c              = 1'b0;
        wb_d                 = wb_q;
        wb_d.valid_in        = 1'b0;
        wb_d.fur_sig         = '0;
        redir_d              = 1'b0;
        redir_pc_d           = redir_pc_q;
        if (ld_rsp_valid_i) begin
            if (is_writable(ld_rsp_dst_i)) begin
                wb_d.valid_in = 1'b1;
                wb_d.addr_in  = ld_rsp_dst_i;
                wb_d.data_in  = ld_rsp_data_i;
            end
        end else if (fifo_count != '0) begin
            pop_c = 1'b1;
            if (head.wb_wr && is_writable(head.reg_dst)) begin
                wb_d.valid_in = 1'b1;
                wb_d.addr_in  = head.reg_dst;
                wb_d.data_in  = head.data;
            end
            if (head.branch) begin
                redir_d                   = 1'b1;
                redir_pc_d                = head.target;
                flush_c                   = 1'b1;
                wb_d.fur_sig.pc_branch    = 1'b1;
            end
        end
    end

    // Pending-load scoreboard; the error check looks at the state before this cycle's clear.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (ld_issue_i && is_writable(ld_issue_dst_i) && busy_q[ld_issue_dst_i]) begin
            err_d = 1'b1;
        end
        if (ld_rsp_valid_i && is_writable(ld_rsp_dst_i)) begin
            busy_d[ld_rsp_dst_i] = 1'b0;
        end
        if (ld_issue_i && is_writable(ld_issue_dst_i)) begin
            busy_d[ld_issue_dst_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wb_q       <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            wb_q       <= wb_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign wb_valid_o       = wb_q.valid_in;
    assign wb_addr_o        = wb_q.addr_in;
    assign wb_data_o        = wb_q.data_in;
    assign wb_pc_branch_o   = wb_q.fur_sig.pc_branch;
    assign redirect_valid_o = redir_q;
    assign redirect_pc_o    = redir_pc_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;

endmodule
